rgb_pwm_driver: RTL and testbench

//  Downstream stage of the RGB colour converter. Takes its 24-bit rgb word and drives

---
 rtl/rgb_pwm_driver_pkg.sv | 41 ++++
 rtl/rgb_pwm_driver_channel.sv | 47 ++++
 rtl/rgb_pwm_driver.sv | 84 ++++++++
 tb/tb_rgb_pwm_driver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_driver_pkg
//  Description : Shared channel slice positions, duty width, colour indices
//                and a duty-slice helper for the RGB PWM driver.
//  Revision    : 1.0  initial release
// ============================================================================
package rgb_pwm_driver_pkg;

    localparam int DUTY_W = 8;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_idx_e;

    function automatic logic [DUTY_W-1:0] duty_slice(input logic [23:0] rgb,
                                                     input ch_idx_e     ch);
        logic [DUTY_W-1:0] d;
        d = '0;
        case (ch)
            CH_R:    d = rgb[R_MSB:R_LSB];
            CH_G:    d = rgb[G_MSB:G_LSB];
            CH_B:    d = rgb[B_MSB:B_LSB];
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage : rgb_pwm_driver_pkg
`default_nettype wire

// File: rtl/rgb_pwm_driver_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One LED channel: period-latched shadow duty, compare against
//                the shared PWM count, registered pin output.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_channel
    import rgb_pwm_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              load,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              led
);

    logic [DUTY_W-1:0] shadow_q;
    logic [DUTY_W-1:0] shadow_d;
    logic              led_q;
    logic              led_d;
    logic [DUTY_W-1:0] w_duty_eff;

    // The new duty must already apply on the load cycle itself, so the
    // first output of a period uses the incoming value, not the stale shadow.
    always_comb begin
        w_duty_eff = load ? duty_in : shadow_q;
        shadow_d   = w_duty_eff;
        led_d      = enable && (pwm_cnt < w_duty_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            led_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule : pwm_channel
`default_nettype wire

// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_driver
//  Description : Drives three LED pins from a 24-bit rgb word with 8-bit PWM;
//                duty is latched once per period.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_pwm_driver
    import rgb_pwm_driver_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] rgb,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        period_start
);

    localparam int             PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]  pre_cnt_q;
    logic [PRE_W-1:0]  pre_cnt_d;
    logic [DUTY_W-1:0] pwm_cnt_q;
    logic [DUTY_W-1:0] pwm_cnt_d;
    logic              period_start_q;
    logic              period_start_d;
    logic              w_tick;
    logic              w_load;
    logic [NUM_CH-1:0] w_led;

    // Counters freeze while disabled, so a disabled stretch simply lengthens
    // the current period instead of restarting it.
    always_comb begin
        w_tick         = enable && (pre_cnt_q == PRE_MAX);
        w_load         = enable && (pre_cnt_q == '0) && (pwm_cnt_q == '0);
        pre_cnt_d      = pre_cnt_q;
        pwm_cnt_d      = pwm_cnt_q;
        period_start_d = w_load;
        if (enable) begin
            pre_cnt_d = w_tick ? '0 : pre_cnt_q + 1'b1;
            if (w_tick) begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_channel u_ch (
                .clk     (clk),
                .rst     (rst),
                .enable  (enable),
                .load    (w_load),
                .pwm_cnt (pwm_cnt_q),
                .duty_in (duty_slice(rgb, ch_idx_e'(gi))),
                .led     (w_led[gi])
            );
        end
    endgenerate

    assign led_r        = w_led[CH_R];
    assign led_g        = w_led[CH_G];
    assign led_b        = w_led[CH_B];
    assign period_start = period_start_q;

endmodule : rgb_pwm_driver
`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_pwm_driver
//  Description : Self-checking bench for rgb_pwm_driver at PRESCALE 1 and 3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, en1, rst3, en3;
    logic [23:0] rgb1, rgb3;
    logic        r1, g1, b1, ps1;
    logic        r3, g3, b3, ps3;

    rgb_pwm_driver #(.PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst1), .enable(en1), .rgb(rgb1),
        .led_r(r1), .led_g(g1), .led_b(b1), .period_start(ps1)
    );

    rgb_pwm_driver #(.PRESCALE(3)) u_p3 (
        .clk(clk), .rst(rst3), .enable(en3), .rgb(rgb3),
        .led_r(r3), .led_g(g3), .led_b(b3), .period_start(ps3)
    );

    typedef struct {
        bit          sel3;
        bit          rst;
        bit          en;
        logic [23:0] rgb;
        int          n;
        int          er, eg, eb, eps;
    } row_t;

    row_t       tbl [17];
    logic [3:0] sb [$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         last_ps  = -1;
    int         ps_gap   = 0;
    int         m_pos    = 0;
    logic [7:0] m_sh [3];

    // Reference: position within the period in enabled clocks; the step is pos/P.
    task automatic step(input bit sel3, input bit r, input bit e,
                        input logic [23:0] c, output logic [3:0] got);
        logic [3:0] exp;
        int         p;
        p = sel3 ? 3 : 1;
        if (sel3) begin
            rst3 = r; en3 = e; rgb3 = c; rst1 = 1'b1; en1 = 1'b0; rgb1 = '0;
        end else begin
            rst1 = r; en1 = e; rgb1 = c; rst3 = 1'b1; en3 = 1'b0; rgb3 = '0;
        end
        exp = 4'b0000;
        if (r) begin
            m_pos = 0;
            m_sh[0] = 8'd0; m_sh[1] = 8'd0; m_sh[2] = 8'd0;
        end else if (e) begin
            if (m_pos == 0) begin
                m_sh[0] = c[23:16]; m_sh[1] = c[15:8]; m_sh[2] = c[7:0];
            end
            exp[3] = (m_pos / p) < int'(m_sh[0]);
            exp[2] = (m_pos / p) < int'(m_sh[1]);
            exp[1] = (m_pos / p) < int'(m_sh[2]);
            exp[0] = (m_pos == 0);
            m_pos  = (m_pos + 1) % (256 * p);
        end
        sb.push_back(exp);
        @(posedge clk);
        #1;
        got = sel3 ? {r3, g3, b3, ps3} : {r1, g1, b1, ps1};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle %0d {r,g,b,ps}: got %b expected %b", cyc, got, exp);
        end
        if (got[0] === 1'b1) begin
            ps_gap  = cyc - last_ps;
            last_ps = cyc;
        end
        cyc++;
    endtask

    initial begin
        logic [3:0] got;
        int cr, cg, cb, cp;
        //          sel3 rst en rgb        n    r    g    b   ps
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 24'hFFFFFF,   3,   0,   0,   0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 24'hFF0000, 512, 510,   0,   0, 2};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 24'h000080, 256,   0,   0, 128, 1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 24'h0000FF, 100,   0,   0, 100, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 24'h00FF00, 156,   0,   0, 155, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 24'h00FF00, 256,   0, 255,   0, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 24'h404040,  50,  50,  50,  50, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 24'h404040,  10,   0,   0,   0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 24'h404040, 206,  14,  14,  14, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 24'h404040,   1,   1,   1,   1, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 24'h404040,   1,   0,   0,   0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 24'h000000, 256,   0,   0,   0, 1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 24'h010203,   2,   0,   0,   0, 0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 24'h010203, 768,   3,   6,   9, 1};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 24'h010203, 600,   3,   6,   9, 1};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 24'h010203,   1,   0,   0,   0, 0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 24'h010203, 768,   3,   6,   9, 1};

        for (int i = 0; i < 17; i++) begin
            cr = 0; cg = 0; cb = 0; cp = 0;
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].sel3, tbl[i].rst, tbl[i].en, tbl[i].rgb, got);
                cr += int'(got[3] === 1'b1);
                cg += int'(got[2] === 1'b1);
                cb += int'(got[1] === 1'b1);
                cp += int'(got[0] === 1'b1);
            end
            checks++;
            if (cr != tbl[i].er || cg != tbl[i].eg || cb != tbl[i].eb || cp != tbl[i].eps) begin
                errors++;
                $display("FAIL row %0d high counts r/g/b/ps: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                         i, cr, cg, cb, cp, tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].eps);
            end
            // Disabled stretch must lengthen the period by exactly its length.
            if (i == 9) begin
                checks++;
                if (ps_gap != 266) begin
                    errors++;
                    $display("FAIL period_gap_after_disable: got %0d expected 266", ps_gap);
                end
            end
        end

        // rst dominates enable mid-period: outputs clear on the very next edge.
        step(1'b1, 1'b0, 1'b1, 24'hFFFFFF, got);
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF, got);
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL rst_priority: got %b expected 0000", got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rgb_pwm_driver
`default_nettype wire
